// File: rtl/gameover_banner.sv
// "GAME OVER" banner overlay: 5x7 glyph ROM text with per-character reveal,
// blink, then steady hold. pix_on is registered one clock after pix_x/pix_y.
module gameover_banner #(
   parameter int unsigned X0            = 212,
   parameter int unsigned Y0            = 224,
   parameter int unsigned SCALE_LOG2    = 2,
   parameter int unsigned REVEAL_FRAMES = 6,
   parameter int unsigned BLINK_FRAMES  = 30,
   parameter int unsigned BLINK_CYCLES  = 3
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [9:0] pix_x_i,
   input  logic [9:0] pix_y_i,
   input  logic       frame_tick_i,
   input  logic       show_i,
   output logic       pix_on_o,
   output logic       active_o,
   output logic       done_o,
   output logic [3:0] chars_visible_o
);

   localparam int unsigned S      = 32'd1 << SCALE_LOG2;
   localparam int unsigned XEnd   = X0 + 54 * S;
   localparam int unsigned YEnd   = Y0 + 8 * S;
   localparam int unsigned CntMax = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned BcW    = (BLINK_CYCLES > 0) ? $clog2(BLINK_CYCLES + 1) : 1;

   localparam logic [CntW-1:0] RevLast = CntW'(REVEAL_FRAMES - 1);
   localparam logic [CntW-1:0] BlkLast = CntW'(BLINK_FRAMES - 1);
   localparam logic [BcW-1:0]  BcLast  = BcW'((BLINK_CYCLES > 0) ? BLINK_CYCLES - 1 : 0);

   // Glyphs packed row 0 first in the MSBs, leftmost column first in each row.
   localparam logic [34:0] GlyphG = 35'b01110_10001_10000_10111_10001_10001_01111;
   localparam logic [34:0] GlyphA = 35'b01110_10001_10001_11111_10001_10001_10001;
   localparam logic [34:0] GlyphM = 35'b10001_11011_10101_10101_10001_10001_10001;
   localparam logic [34:0] GlyphE = 35'b11111_10000_10000_11110_10000_10000_11111;
   localparam logic [34:0] GlyphO = 35'b01110_10001_10001_10001_10001_10001_01110;
   localparam logic [34:0] GlyphV = 35'b10001_10001_10001_10001_10001_01010_00100;
   localparam logic [34:0] GlyphR = 35'b11110_10001_10001_11110_10100_10010_10001;

   typedef enum logic [1:0] {StIdle, StReveal, StBlink, StHold} state_e;

   state_e          state_q, state_d;
   logic [3:0]      chars_q, chars_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            phase_q, phase_d;
   logic [BcW-1:0]  bc_q, bc_d;
   logic            pix_on_q, pix_on_d;

   logic [31:0] x_ext, y_ext;
   logic        in_win;
   logic [5:0]  ux;
   logic [2:0]  uy;
   logic [3:0]  ch;
   logic [2:0]  col;
   logic [34:0] glyph;
   logic [4:0]  row_bits;
   logic [4:0]  shifted;

   always_comb begin
      state_d = state_q;
      chars_d = chars_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      bc_d    = bc_q;
      if (!show_i) begin
         state_d = StIdle;
         chars_d = 4'd0;
         cnt_d   = '0;
         phase_d = 1'b1;
         bc_d    = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StReveal;
               chars_d = 4'd0;
               cnt_d   = '0;
               phase_d = 1'b1;
               bc_d    = '0;
            end
            StReveal: begin
               if (frame_tick_i) begin
                  if (cnt_q == RevLast) begin
                     cnt_d   = '0;
                     chars_d = chars_q + 4'd1;
                     if (chars_q == 4'd8) begin
                        phase_d = 1'b1;
                        state_d = (BLINK_CYCLES == 0) ? StHold : StBlink;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StBlink: begin
               if (frame_tick_i) begin
                  if (cnt_q == BlkLast) begin
                     cnt_d   = '0;
                     phase_d = ~phase_q;
                     // A full off->on cycle completes on the rising toggle
                     if (!phase_q) begin
                        bc_d = bc_q + 1'b1;
                        if (bc_q == BcLast) begin
                           state_d = StHold;
                           phase_d = 1'b1;
                        end
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StHold: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      x_ext  = {22'd0, pix_x_i};
      y_ext  = {22'd0, pix_y_i};
      in_win = (x_ext >= X0) && (x_ext < XEnd) && (y_ext >= Y0) && (y_ext < YEnd);
      ux     = 6'((x_ext - X0) >> SCALE_LOG2);
      uy     = 3'((y_ext - Y0) >> SCALE_LOG2);
      ch     = 4'(ux / 6'd6);
      col    = 3'(ux % 6'd6);

      unique case (ch)
         4'd0:    glyph = GlyphG;
         4'd1:    glyph = GlyphA;
         4'd2:    glyph = GlyphM;
         4'd3:    glyph = GlyphE;
         4'd5:    glyph = GlyphO;
         4'd6:    glyph = GlyphV;
         4'd7:    glyph = GlyphE;
         4'd8:    glyph = GlyphR;
         default: glyph = '0;
      endcase

      unique case (uy)
         3'd0:    row_bits = glyph[34:30];
         3'd1:    row_bits = glyph[29:25];
         3'd2:    row_bits = glyph[24:20];
         3'd3:    row_bits = glyph[19:15];
         3'd4:    row_bits = glyph[14:10];
         3'd5:    row_bits = glyph[9:5];
         3'd6:    row_bits = glyph[4:0];
         default: row_bits = '0;
      endcase

      shifted = row_bits << col;
      // Gating with show blanks the clock where the banner is being torn down
      pix_on_d = show_i && in_win && (col < 3'd5) && (uy != 3'd7) && (ch < chars_q) &&
                 phase_q && shifted[4];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         chars_q  <= 4'd0;
         cnt_q    <= '0;
         phase_q  <= 1'b1;
         bc_q     <= '0;
         pix_on_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         chars_q  <= chars_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         bc_q     <= bc_d;
         pix_on_q <= pix_on_d;
      end
   end

   assign pix_on_o        = pix_on_q;
   assign active_o        = (state_q != StIdle);
   assign done_o          = (state_q == StHold);
   assign chars_visible_o = chars_q;

endmodule

// File: tb/tb_gameover_banner.sv
// Directed bench for gameover_banner: default-parameter instance for reveal/blink/abort,
// and a no-blink, fast-reveal instance for the full glyph sweep.
module tb_gameover_banner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, show, frame_tick;
   logic [9:0] pix_x, pix_y;
   logic       a_pix_on, a_active, a_done;
   logic [3:0] a_chars;
   logic       b_pix_on, b_active, b_done;
   logic [3:0] b_chars;

   int n_vec = 0;
   int n_err = 0;
   string glyphs [9];

   gameover_banner u_a (
      .clk_i           (clk),
      .reset_i         (reset),
      .pix_x_i         (pix_x),
      .pix_y_i         (pix_y),
      .frame_tick_i    (frame_tick),
      .show_i          (show),
      .pix_on_o        (a_pix_on),
      .active_o        (a_active),
      .done_o          (a_done),
      .chars_visible_o (a_chars)
   );

   gameover_banner #(
      .REVEAL_FRAMES (1),
      .BLINK_CYCLES  (0)
   ) u_b (
      .clk_i           (clk),
      .reset_i         (reset),
      .pix_x_i         (pix_x),
      .pix_y_i         (pix_y),
      .frame_tick_i    (frame_tick),
      .show_i          (show),
      .pix_on_o        (b_pix_on),
      .active_o        (b_active),
      .done_o          (b_done),
      .chars_visible_o (b_chars)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         step();
         frame_tick = 1'b0;
         step();
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic probe(input int x, input int y);
      pix_x = 10'(x);
      pix_y = 10'(y);
      step();
   endtask

   // Reference pixel for a fully revealed, steadily lit banner at X0=212, Y0=224, unit 4.
   function automatic logic exp_pix(input int x, input int y);
      int    ux, uy, c, col;
      string s;
      if (x < 212 || x >= 428 || y < 224 || y >= 256) return 1'b0;
      ux  = (x - 212) / 4;
      uy  = (y - 224) / 4;
      c   = ux / 6;
      col = ux % 6;
      if (col > 4 || uy > 6) return 1'b0;
      s = glyphs[c];
      return (s[uy * 5 + col] == "1");
   endfunction

   initial begin
      int bad;
      glyphs[0] = {"01110", "10001", "10000", "10111", "10001", "10001", "01111"};
      glyphs[1] = {"01110", "10001", "10001", "11111", "10001", "10001", "10001"};
      glyphs[2] = {"10001", "11011", "10101", "10101", "10001", "10001", "10001"};
      glyphs[3] = {"11111", "10000", "10000", "11110", "10000", "10000", "11111"};
      glyphs[4] = {"00000", "00000", "00000", "00000", "00000", "00000", "00000"};
      glyphs[5] = {"01110", "10001", "10001", "10001", "10001", "10001", "01110"};
      glyphs[6] = {"10001", "10001", "10001", "10001", "10001", "01010", "00100"};
      glyphs[7] = glyphs[3];
      glyphs[8] = {"11110", "10001", "10001", "11110", "10100", "10010", "10001"};

      reset = 1'b1; show = 1'b1; frame_tick = 1'b0; pix_x = 10'd216; pix_y = 10'd224;
      repeat (3) step();
      chk("rst_pix_on", 32'(a_pix_on), 0);
      chk("rst_active", 32'(a_active), 0);
      chk("rst_done", 32'(a_done), 0);
      chk("rst_chars", 32'(a_chars), 0);

      reset = 1'b0;
      step();
      chk("rel_active", 32'(a_active), 1);
      chk("rel_chars", 32'(a_chars), 0);

      frames(5);
      chk("rev_5ticks", 32'(a_chars), 0);
      frames(1);
      chk("rev_6ticks", 32'(a_chars), 1);

      probe(216, 224); chk("pix_g_r0c1", 32'(a_pix_on), 1);
      probe(212, 224); chk("pix_g_r0c0", 32'(a_pix_on), 0);
      probe(232, 230); chk("pix_gap_col", 32'(a_pix_on), 0);
      probe(236, 236); chk("pix_a_hidden", 32'(a_pix_on), 0);
      probe(216, 223); chk("pix_above", 32'(a_pix_on), 0);
      probe(216, 224);

      frames(47);
      chk("rev_53ticks", 32'(a_chars), 8);
      frames(1);
      chk("rev_54ticks", 32'(a_chars), 9);
      chk("blink_entry_done", 32'(a_done), 0);
      chk("blink_entry_active", 32'(a_active), 1);

      frames(29); chk("blink_t29", 32'(a_pix_on), 1);
      frames(1);  chk("blink_t30", 32'(a_pix_on), 0);
      frames(30); chk("blink_t60", 32'(a_pix_on), 1);
      frames(119); chk("blink_t179_done", 32'(a_done), 0);
      frames(1);   chk("blink_t180_done", 32'(a_done), 1);
      frames(3);
      chk("hold_ignores_tick", 32'(a_done), 1);
      chk("hold_chars", 32'(a_chars), 9);
      chk("hold_pix", 32'(a_pix_on), 1);

      show = 1'b0; step();
      chk("drop_hold_active", 32'(a_active), 0);
      show = 1'b1; step();
      chk("restart_active", 32'(a_active), 1);
      chk("restart_chars", 32'(a_chars), 0);
      frames(54);
      chk("rerun_chars", 32'(a_chars), 9);
      frames(10);

      show = 1'b0; frame_tick = 1'b1; step(); frame_tick = 1'b0;
      chk("abort_active", 32'(a_active), 0);
      chk("abort_chars", 32'(a_chars), 0);
      chk("abort_done", 32'(a_done), 0);
      chk("abort_pix", 32'(a_pix_on), 0);
      bad = 0;
      for (int y = 223; y <= 256; y++) begin
         for (int x = 211; x <= 428; x++) begin
            probe(x, y);
            if (a_pix_on !== 1'b0) bad++;
         end
      end
      chk("abort_sweep_lit", 32'(bad), 0);

      show = 1'b1; step();
      frames(8);
      chk("mid_chars", 32'(a_chars), 1);
      reset = 1'b1; step();
      chk("mid_rst_active", 32'(a_active), 0);
      chk("mid_rst_chars", 32'(a_chars), 0);
      reset = 1'b0; step();

      frames(8);
      chk("b_8ticks_chars", 32'(b_chars), 8);
      chk("b_8ticks_done", 32'(b_done), 0);
      frame_tick = 1'b1; step(); frame_tick = 1'b0;
      chk("b_9th_done", 32'(b_done), 1);
      chk("b_9th_chars", 32'(b_chars), 9);

      probe(236, 236); chk("b_pix_a_r3c0", 32'(b_pix_on), 1);
      bad = 0;
      for (int y = 223; y <= 256; y++) begin
         for (int x = 211; x <= 428; x++) begin
            probe(x, y);
            if (b_pix_on !== exp_pix(x, y)) begin
               if (bad == 0) $display("first sweep difference at (%0d,%0d): %b", x, y, b_pix_on);
               bad++;
            end
         end
      end
      chk("b_sweep_diffs", 32'(bad), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
